// File: rtl/fadd_share_arbiter.sv
// -----------------------------------------------------------------------------
// fadd_share_arbiter
//
// Shares one external combinational single-precision float adder among N_REQ
// requesters. A requester is accepted round-robin in IDLE, its operands are
// registered and presented to the adder for one EXEC cycle, and the captured
// sum is held on a valid/ready response channel (RESP) until the owning
// requester takes it.
//
// Optional feature (compile-time macro FADD_SUB_EN):
//   defined     - req_sub[i] flips the sign of operand B at grant, so the same
//                 adder performs A - B.
//   not defined - req_sub is ignored and B is passed through unmodified.
//
// Parameters:
//   N_REQ  number of requesters (1..8)
//   CNT_W  width of the saturating completed-operation counter
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operation request
//   req_ready  one-hot accept, combinational, only asserted in IDLE
//   req_a      operand A, requester i at [32i+31:32i]
//   req_b      operand B, same packing
//   req_sub    per-requester subtract request (FADD_SUB_EN only)
//   rsp_valid  one-hot result valid for the owning requester
//   rsp_ready  per-requester result accept (only the owner's bit is used)
//   rsp_data   result word shared by all requesters, zero outside RESP
//   add_a      operand A to the shared adder
//   add_b      operand B to the shared adder
//   add_out    adder result, combinational from add_a/add_b
//   busy       high whenever the FSM is not in IDLE
//   op_count   completed operations, saturating at all-ones
// -----------------------------------------------------------------------------
module fadd_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_sub,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_out,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]   NREQ_L = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_L = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [PTR_W:0] pick_grant(input logic [N_REQ-1:0] valid,
                                                input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0]   idx;
    logic             found;
    logic [PTR_W-1:0] grant;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (idx >= NREQ_L) begin
        idx = idx - NREQ_L;
      end else begin
        idx = idx;
      end
      if (!found && valid[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        grant = idx[PTR_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, grant};
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W-1:0]  owner_r;
  logic [PTR_W-1:0]  ptr_nxt_s;
  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [31:0]       res_r;
  logic [CNT_W-1:0]  op_count_r;
  logic [PTR_W:0]    pick_s;
  logic              found_s;
  logic [PTR_W-1:0]  grant_s;
  logic [31:0]       a_arr_s [N_REQ];
  logic [31:0]       b_arr_s [N_REQ];
  logic [31:0]       b_eff_s;

  // Unpack the flat operand buses into per-requester words.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr_s[gi] = req_a[32*gi +: 32];
    assign b_arr_s[gi] = req_b[32*gi +: 32];
  end

  assign pick_s  = pick_grant(req_valid, rr_ptr_r);
  assign found_s = pick_s[PTR_W];
  assign grant_s = pick_s[PTR_W-1:0];

`ifdef FADD_SUB_EN
  // Subtraction is a sign flip of B so the same adder computes A - B.
  assign b_eff_s = {b_arr_s[grant_s][31] ^ req_sub[grant_s], b_arr_s[grant_s][30:0]};
`else
  logic unused_sub_s;
  assign b_eff_s      = b_arr_s[grant_s];
  assign unused_sub_s = ^req_sub;
`endif

  // Pointer moves just past the owner; a single requester keeps it at 0.
  assign ptr_nxt_s = (owner_r == LAST_L) ? '0 : owner_r + PTR_W'(1);

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready[owner_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand/result capture, round-robin pointer and op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      res_r      <= 32'd0;
      op_count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            a_r     <= a_arr_s[grant_s];
            b_r     <= b_eff_s;
            owner_r <= grant_s;
          end
        end
        EXEC: res_r <= add_out;
        RESP: begin
          if (rsp_ready[owner_r]) begin
            rr_ptr_r <= ptr_nxt_s;
            if (op_count_r != {CNT_W{1'b1}}) begin
              op_count_r <= op_count_r + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state; everything idles at zero.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = 32'd0;
    add_a     = 32'd0;
    add_b     = 32'd0;
    busy      = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          req_ready[grant_s] = 1'b1;
        end else begin
          req_ready = '0;
        end
      end
      EXEC: begin
        add_a = a_r;
        add_b = b_r;
        busy  = 1'b1;
      end
      RESP: begin
        rsp_valid[owner_r] = 1'b1;
        rsp_data           = res_r;
        add_a              = a_r;
        add_b              = b_r;
        busy               = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign op_count = op_count_r;

endmodule
